// File: rtl/i2c_bit_controller.sv
// I2C master bit sequencer: runs START / STOP / WRITE / READ bit commands against the
// external SCL generator and the synchronised bus lines, reporting done, rd_bit and arb_lost.
module i2c_bit_controller #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic       cmd_bit,
   output logic       done,
   output logic       rd_bit,
   output logic       arb_lost,
   output logic       busy,
   output logic       scl_en,
   output logic       scl_wait,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o
);

   typedef enum logic [1:0] {
      CMD_START = 2'b00,
      CMD_STOP  = 2'b01,
      CMD_WRITE = 2'b10,
      CMD_READ  = 2'b11
   } cmd_t;

   typedef enum logic [4:0] {
      S_IDLE, S_START_HOLD, S_START_FALL, S_PARKED,
      S_RS_SETUP, S_RS_RISE, S_RS_HOLD1, S_RS_HOLD2, S_RS_FALL,
      S_WR_SETUP, S_WR_RISE, S_WR_FALL,
      S_RD_SETUP, S_RD_RISE, S_RD_FALL,
      S_STOP_SETUP, S_STOP_RISE, S_STOP_HOLD1, S_STOP_HOLD2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       bit_q, bit_n;
   logic       rd_sample, samp_n;
   logic       scl_en_n, scl_wait_n, sda_n, done_n, arb_n, busy_n, rd_n;
   logic [1:0] scl_sync, sda_sync;
   logic       scl_last;
   logic       scl_s, sda_s, scl_rise, scl_fall, hold_end;

   // Both lines share the same sync depth so SDA is sampled aligned with the SCL edge.
   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = !scl_last && scl_s;
   assign scl_fall  = scl_last && !scl_s;
   assign hold_end  = (cnt == HOLD_LAST);
   assign cmd_ready = en && (state == S_IDLE || state == S_PARKED);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_n      = bit_q;
      samp_n     = rd_sample;
      scl_en_n   = scl_en;
      scl_wait_n = scl_wait;
      sda_n      = sda_o;
      done_n     = 1'b0;
      arb_n      = 1'b0;
      busy_n     = busy;
      rd_n       = rd_bit;
      if (!en) begin
         state_n    = S_IDLE;
         cnt_n      = '0;
         bit_n      = 1'b0;
         samp_n     = 1'b0;
         scl_en_n   = 1'b0;
         scl_wait_n = 1'b0;
         sda_n      = 1'b1;
         busy_n     = 1'b0;
         rd_n       = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_t'(cmd))
                     CMD_START: begin
                        if (!scl_s || !sda_s) begin
                           arb_n = 1'b1;
                        end else begin
                           sda_n   = 1'b0;
                           cnt_n   = '0;
                           state_n = S_START_HOLD;
                        end
                     end
                     CMD_STOP:            done_n = 1'b1;
                     CMD_WRITE, CMD_READ: arb_n  = 1'b1;
                  endcase
               end
            end
            S_START_HOLD: begin
               if (hold_end) begin
                  scl_en_n   = 1'b1;
                  scl_wait_n = 1'b0;
                  state_n    = S_START_FALL;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            S_START_FALL: begin
               if (scl_fall) begin
                  scl_wait_n = 1'b1;
                  done_n     = 1'b1;
                  busy_n     = 1'b1;
                  state_n    = S_PARKED;
               end
            end
            S_PARKED: begin
               if (cmd_valid) begin
                  bit_n = cmd_bit;
                  // SDA settles here with SCL still parked; the SETUP states release SCL one cycle later.
                  case (cmd_t'(cmd))
                     CMD_START: begin sda_n = 1'b1;    state_n = S_RS_SETUP;   end
                     CMD_STOP:  begin sda_n = 1'b0;    state_n = S_STOP_SETUP; end
                     CMD_WRITE: begin sda_n = cmd_bit; state_n = S_WR_SETUP;   end
                     CMD_READ:  begin sda_n = 1'b1;    state_n = S_RD_SETUP;   end
                  endcase
               end
            end
            S_RS_SETUP:   begin scl_wait_n = 1'b0; state_n = S_RS_RISE;   end
            S_WR_SETUP:   begin scl_wait_n = 1'b0; state_n = S_WR_RISE;   end
            S_RD_SETUP:   begin scl_wait_n = 1'b0; state_n = S_RD_RISE;   end
            S_STOP_SETUP: begin scl_wait_n = 1'b0; state_n = S_STOP_RISE; end
            S_RS_RISE: begin
               if (scl_rise) begin
                  cnt_n   = '0;
                  state_n = S_RS_HOLD1;
               end
            end
            S_RS_HOLD1: begin
               if (hold_end) begin
                  sda_n   = 1'b0;
                  cnt_n   = '0;
                  state_n = S_RS_HOLD2;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            S_RS_HOLD2: begin
               if (hold_end) state_n = S_RS_FALL;
               else          cnt_n   = cnt + 8'd1;
            end
            S_WR_RISE: begin
               if (scl_rise) begin
                  if (bit_q && !sda_s) begin
                     arb_n      = 1'b1;
                     sda_n      = 1'b1;
                     scl_en_n   = 1'b0;
                     scl_wait_n = 1'b0;
                     busy_n     = 1'b0;
                     state_n    = S_IDLE;
                  end else begin
                     state_n = S_WR_FALL;
                  end
               end
            end
            S_RD_RISE: begin
               if (scl_rise) begin
                  samp_n  = sda_s;
                  state_n = S_RD_FALL;
               end
            end
            S_RS_FALL, S_WR_FALL, S_RD_FALL: begin
               if (scl_fall) begin
                  scl_wait_n = 1'b1;
                  done_n     = 1'b1;
                  state_n    = S_PARKED;
                  if (state == S_RD_FALL) rd_n = rd_sample;
               end
            end
            S_STOP_RISE: begin
               if (scl_rise) begin
                  scl_en_n = 1'b0;
                  cnt_n    = '0;
                  state_n  = S_STOP_HOLD1;
               end
            end
            S_STOP_HOLD1: begin
               if (hold_end) begin
                  sda_n   = 1'b1;
                  cnt_n   = '0;
                  state_n = S_STOP_HOLD2;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            S_STOP_HOLD2: begin
               if (hold_end) begin
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = S_IDLE;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_q     <= 1'b0;
         rd_sample <= 1'b0;
         scl_en    <= 1'b0;
         scl_wait  <= 1'b0;
         sda_o     <= 1'b1;
         done      <= 1'b0;
         arb_lost  <= 1'b0;
         busy      <= 1'b0;
         rd_bit    <= 1'b0;
         scl_sync  <= '1;
         sda_sync  <= '1;
         scl_last  <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_q     <= bit_n;
         rd_sample <= samp_n;
         scl_en    <= scl_en_n;
         scl_wait  <= scl_wait_n;
         sda_o     <= sda_n;
         done      <= done_n;
         arb_lost  <= arb_n;
         busy      <= busy_n;
         rd_bit    <= rd_n;
         scl_sync  <= {scl_sync[0], scl_i};
         sda_sync  <= {sda_sync[0], sda_i};
         scl_last  <= scl_s;
      end
   end

endmodule

// File: tb/tb_i2c_bit_controller.sv
// Bench for i2c_bit_controller: emulated SCL generator and slave on wired-AND lines,
// response scoreboard, bus-event monitor and per-cycle output checks.
module tb_i2c_bit_controller;
   localparam int unsigned HOLD = 4;
   localparam int          HALF = 16;
   localparam logic [1:0]  C_START = 2'b00, C_STOP = 2'b01, C_WRITE = 2'b10, C_READ = 2'b11;

   logic clk = 1'b0, rst_n = 1'b1, en = 1'b1, cmd_valid = 1'b0, cmd_bit = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic cmd_ready, done, rd_bit, arb_lost, busy, scl_en, scl_wait, sda_o;
   logic scl_i, sda_i;
   logic gen_scl = 1'b1, slave_sda = 1'b1;
   int   st_cnt = 0, stretch = 0, ph = 0;

   assign scl_i = gen_scl && (st_cnt == 0);
   assign sda_i = sda_o & slave_sda;

   i2c_bit_controller #(.HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .cmd_bit(cmd_bit), .done(done), .rd_bit(rd_bit), .arb_lost(arb_lost),
      .busy(busy), .scl_en(scl_en), .scl_wait(scl_wait), .scl_i(scl_i), .sda_i(sda_i),
      .sda_o(sda_o)
   );

   always #5 clk = ~clk;

   // SCL generator: HALF-cycle phases, parks low on scl_wait, slave may stretch the low phase.
   always @(posedge clk) begin
      #1;
      if (st_cnt > 0) st_cnt--;
      if (scl_en !== 1'b1) begin
         gen_scl = 1'b1; ph = 0; st_cnt = 0;
      end else if (gen_scl) begin
         if (scl_i) begin
            if (ph == HALF - 1) begin gen_scl = 1'b0; ph = 0; end
            else ph++;
         end
      end else if (scl_wait) begin
         ph = 0;
      end else if (ph == HALF - 1) begin
         gen_scl = 1'b1; ph = 0; st_cnt = stretch;
      end else begin
         ph++;
      end
   end

   typedef struct {
      logic       is_arb;
      logic       chk_rd;
      logic       rd;
      logic [1:0] c;
   } exp_t;

   exp_t expq[$];
   exp_t cur_e;
   byte  ev[$];
   int   nchk = 0, nerr = 0, ndone = 0;
   int   start_gap = 0, stop_gap = 0, s_cyc = 0, r_cyc = 0, cyc = 0;
   bit   s_pend = 0, en_seen = 0, in_cmd = 0, mb = 0, mrd = 0;
   bit   prev_scl = 1, prev_sda = 1, prev_wait = 0, prev_sdao = 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endfunction

   function automatic void chk_ev(input string name, input string req);
      string got = "";
      foreach (ev[i]) got = {got, $sformatf("%c", ev[i])};
      nchk++;
      if (got != req) begin
         nerr++;
         $display("FAIL %s: bus events '%s', required '%s'", name, got, req);
      end
   endfunction

   always @(posedge clk) en_seen <= en;

   always @(negedge clk) begin
      cyc++;
      if (scl_i && prev_scl && (sda_i !== prev_sda)) begin
         if (!sda_i) begin ev.push_back(8'h53); s_cyc = cyc; s_pend = 1; end
         else begin ev.push_back(8'h50); stop_gap = cyc - r_cyc; end
      end
      if (scl_i && !prev_scl) begin
         ev.push_back(sda_i ? 8'h31 : 8'h30);
         r_cyc = cyc;
      end
      if (!scl_i && prev_scl && s_pend) begin
         start_gap = cyc - s_cyc; s_pend = 0;
      end

      if (!rst_n || !en_seen) begin
         chk("rst_scl_en", scl_en, 0);
         chk("rst_scl_wait", scl_wait, 0);
         chk("rst_sda_o", sda_o, 1);
         chk("rst_done", done, 0);
         chk("rst_arb_lost", arb_lost, 0);
         chk("rst_rd_bit", rd_bit, 0);
         chk("rst_busy", busy, 0);
         if (!en) chk("rst_cmd_ready", cmd_ready, 0);
         expq.delete(); in_cmd = 0; mb = 0; mrd = 0;
      end else begin
         chk("done_arb_exclusive", done && arb_lost, 0);
         if (done || arb_lost) begin
            if (done) ndone++;
            if (expq.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL unexpected_resp: done=%0b arb_lost=%0b, required none outstanding", done, arb_lost);
            end else begin
               cur_e = expq.pop_front();
               chk("resp_kind_arb", arb_lost, cur_e.is_arb);
               if (arb_lost) mb = 0;
               else if (cur_e.c == C_START) mb = 1;
               else if (cur_e.c == C_STOP) mb = 0;
               if (done && cur_e.chk_rd) mrd = cur_e.rd;
            end
            in_cmd = 0;
         end
         chk("busy", busy, mb);
         chk("rd_bit_held", rd_bit, mrd);
         chk("cmd_ready", cmd_ready, en && (!in_cmd || done || arb_lost));
         if (prev_wait && !scl_wait && scl_en) chk("sda_stable_before_release", sda_o, prev_sdao);
      end
      prev_scl = scl_i; prev_sda = sda_i; prev_wait = scl_wait; prev_sdao = sda_o;
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic send(input logic [1:0] c, input logic b);
      int n = 0;
      tick();
      while (!cmd_ready && n < 500) begin tick(); n++; end
      if (!cmd_ready) begin
         nchk++; nerr++;
         $display("FAIL ready_timeout: cmd_ready=0 after %0d cycles, required 1", n);
      end
      cmd = c; cmd_bit = b; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0; in_cmd = 1;
   endtask

   task automatic run_cmd(input logic [1:0] c, input logic b, input logic is_arb,
                          input logic rdv, output int lat);
      exp_t e;
      e.is_arb = is_arb; e.chk_rd = (c == C_READ) && !is_arb; e.rd = rdv; e.c = c;
      expq.push_back(e);
      send(c, b);
      lat = 0;
      while (in_cmd && lat < 2000) begin @(negedge clk); #1; lat++; end
      if (in_cmd) begin
         nchk++; nerr++;
         $display("FAIL resp_timeout: cmd=%0d no done/arb_lost in %0d cycles, required one", c, lat);
         in_cmd = 0; expq.delete();
      end
   endtask

   task automatic wait_scl_high();
      int n = 0;
      while (!scl_i && n < 200) begin tick(); n++; end
      chk("scl_rose", scl_i, 1);
   endtask

   initial begin
      int lat, lat0, lat1, nd0;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_sda_o", sda_o, 1);
      chk("reset_scl_en", scl_en, 0);

      // 1: START, WRITE 1,0,1, STOP
      ev.delete(); nd0 = ndone;
      run_cmd(C_START, 0, 0, 0, lat);
      chk("t1_busy_after_start", busy, 1);
      run_cmd(C_WRITE, 1, 0, 0, lat);
      run_cmd(C_WRITE, 0, 0, 0, lat);
      run_cmd(C_WRITE, 1, 0, 0, lat);
      chk("t1_busy_before_stop", busy, 1);
      run_cmd(C_STOP, 0, 0, 0, lat);
      chk("t1_busy_after_stop", busy, 0);
      chk("t1_done_count", ndone - nd0, 5);
      chk_ev("t1_bus", "S1010P");
      chk("t1_start_hold_ge4", start_gap >= int'(HOLD), 1);
      chk("t1_stop_hold_ge4", stop_gap >= int'(HOLD), 1);

      // 2: READ 0 then 1, repeated START, STOP
      ev.delete();
      run_cmd(C_START, 0, 0, 0, lat);
      slave_sda = 1'b0;
      run_cmd(C_READ, 0, 0, 0, lat0);
      chk("t2_rd0", rd_bit, 0);
      slave_sda = 1'b1;
      run_cmd(C_READ, 0, 0, 1, lat);
      chk("t2_rd1", rd_bit, 1);
      run_cmd(C_START, 0, 0, 0, lat);
      chk("t2_busy_after_rs", busy, 1);
      run_cmd(C_STOP, 0, 0, 0, lat);
      chk_ev("t2_bus", "S011S0P");

      // 5: stretched READ
      run_cmd(C_START, 0, 0, 0, lat);
      stretch = 10; slave_sda = 1'b0;
      run_cmd(C_READ, 0, 0, 0, lat1);
      stretch = 0; slave_sda = 1'b1;
      chk("t5_rd_stretch", rd_bit, 0);
      chk("t5_delay_ge10", lat1 >= lat0 + 10, 1);
      run_cmd(C_STOP, 0, 0, 0, lat);

      // 3: WRITE 1 loses arbitration
      run_cmd(C_START, 0, 0, 0, lat);
      slave_sda = 1'b0;
      run_cmd(C_WRITE, 1, 1, 0, lat);
      chk("t3_scl_en", scl_en, 0);
      chk("t3_sda_o", sda_o, 1);
      chk("t3_busy", busy, 0);
      slave_sda = 1'b1;
      repeat (5) tick();

      // 4: START with SDA held low; idle WRITE; idle STOP
      slave_sda = 1'b0;
      repeat (5) tick();
      run_cmd(C_START, 0, 1, 0, lat);
      chk("t4_arb_within4", lat <= 4, 1);
      repeat (5) tick();
      chk("t4_scl_en_stays0", scl_en, 0);
      slave_sda = 1'b1;
      repeat (5) tick();
      run_cmd(C_WRITE, 1, 1, 0, lat);
      run_cmd(C_STOP, 0, 0, 0, lat);
      chk("t4_stop_idle_lat", lat, 1);

      // 6: en dropped mid-WRITE, rst_n pulsed mid-READ
      run_cmd(C_START, 0, 0, 0, lat);
      send(C_WRITE, 1);
      wait_scl_high();
      en = 1'b0;
      repeat (2) tick();
      chk("t6_en_scl_en", scl_en, 0);
      chk("t6_en_sda_o", sda_o, 1);
      chk("t6_en_busy", busy, 0);
      en = 1'b1;
      repeat (3) tick();
      run_cmd(C_START, 0, 0, 0, lat);
      chk("t6_restart_busy", busy, 1);
      send(C_READ, 0);
      wait_scl_high();
      rst_n = 1'b0;
      repeat (2) tick();
      chk("t6_rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (3) tick();
      run_cmd(C_START, 0, 0, 0, lat);
      chk("t6_final_busy", busy, 1);
      run_cmd(C_STOP, 0, 0, 0, lat);
      chk("t6_final_idle", busy, 0);

      repeat (5) tick();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run still active at 500000 ns, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
